tl_ul_sram_bridge: RTL
======================

TL_UL_SRAM_BRIDGE -- requirements
Module: tl_ul_sram_bridge

Interface
REQ-001 SHALL have parameters, one per line (name, default, meaning):
  ADDR_W, 26, TileLink byte-address width.
  SRC_W, 2, TileLink source-ID width.
  RSP_DEPTH, 3, response FIFO entries (fixed; no other value supported).
REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
  clock  in  1  single clock; all state on rising edge.
  reset_n  in  1  reset; asynchronous, active-low.
  a_valid  in  1  A-channel request valid, from the upstream fragmenter.
  a_ready  out  1  A-channel accept.
  a_opcode  in  3  TL opcode.
  a_param  in  3  ignored.
  a_size  in  3  log2 bytes.
  a_source  in  SRC_W  request ID.
  a_address  in  ADDR_W  byte address.
  a_mask  in  4  byte lanes.
  a_data  in  32  write data.
  d_valid  out  1  response valid.
  d_ready  in  1  response accept.
  d_opcode  out  3  AccessAck=0, AccessAckData=1, HintAck=2.
  d_param  out  2  always 0.
  d_size  out  3  echo of a_size.
  d_source  out  SRC_W  echo of a_source.
  d_denied  out  1  request rejected.
  d_data  out  32  read data; 0 when d_opcode is not 1.
  d_corrupt  out  1  equals d_denied for AccessAckData, else 0.
  mem_req  out  1  memory access strobe.
  mem_we  out  1  write when 1.
  mem_addr  out  ADDR_W-2  word address = a_address[ADDR_W-1:2].
  mem_wmask  out  4  byte enables = a_mask.
  mem_wdata  out  32  = a_data.
  mem_rdata  in  32  read data, valid exactly 1 cycle after a read mem_req.
  mem_err  in  1  error, valid with mem_rdata timing (1 cycle after mem_req).

Function
REQ-003 SHALL accept an A beat on a_valid & a_ready (the "fire" cycle T); each fire yields exactly one D response.
REQ-004 SHALL drive a_ready = (fifo_count + s1_valid) < 3; a_ready SHALL NOT depend combinationally on d_ready or a_valid.
REQ-005 Legal request: opcode in {0 PutFull, 1 PutPartial, 4 Get}, a_size <= 2, address aligned to 2^a_size.
REQ-006 On a legal fire, mem_req SHALL be 1 combinationally in cycle T, with mem_we=1 for Put and 0 for Get; otherwise mem_req=0.
REQ-007 Illegal requests SHALL NOT assert mem_req.
  Opcodes 2, 3 (atomics): AccessAckData, denied=1.
  Opcode 5 (Intent): HintAck, denied=0.
  Opcodes 6, 7, size > 2, or misalignment: Get-class -> AccessAckData, Put-class -> AccessAck; denied=1.
REQ-008 Stage s1 SHALL register the fire's metadata (opcode class, size, source, denied, is_mem) at the end of T; s1_valid=1 in T+1.
REQ-009 In T+1 s1 SHALL push into the FIFO unconditionally.
  Read: data = mem_rdata; denied |= mem_err.
  Write: denied |= mem_err.
REQ-010 The FIFO head SHALL drive the D channel; d_valid = fifo_count != 0; pop on d_valid & d_ready.
  Minimum fire-to-d_valid latency is 2 cycles (d_valid first high in T+2).
REQ-011 Ordering: responses SHALL return in acceptance order.
REQ-012 Throughput: sustained 1 request per cycle while d_ready=1.
REQ-013 Simultaneous FIFO push and pop SHALL leave fifo_count unchanged; the FIFO pointers wrap modulo 3.
REQ-014 The D payload SHALL be held stable while d_valid=1 and d_ready=0.
REQ-015 Overflow SHALL be impossible by construction of REQ-004.
  Implementation includes an assertion (simulation only) that no push occurs when fifo_count=3 without a simultaneous pop.

Reset
REQ-016 Asserting reset_n=0 SHALL asynchronously clear s1_valid, fifo_count and the FIFO pointers; outputs SHALL then be a_ready=1, d_valid=0, mem_req=0.
REQ-017 Reset mid-operation SHALL discard all in-flight responses; no D beat is emitted for requests accepted before reset.
REQ-018 Deassertion of reset is synchronized externally; the first fire may occur in the first cycle after deassertion.
REQ-019 FIFO data storage SHALL NOT require reset; D payload fields are don't-care while d_valid=0.

Verification
REQ-020 Get at address 0x0000104, size 2, source 1, mem_rdata=0xDEADBEEF at T+1 -> d_valid at T+2 with opcode 1, data 0xDEADBEEF, source 1, denied 0.
REQ-021 PutPartial with mask 0x3 at address 0x10 -> mem_we=1, mem_addr=0x4, mem_wmask=0x3 in T; AccessAck, denied 0.
REQ-022 Get with size 2 at address 0x2 -> mem_req=0; AccessAckData with denied=1, corrupt=1, data 0.
REQ-023 d_ready=0 with 4 back-to-back Gets -> 3 accepted, a_ready=0 after the third; raising d_ready returns 3 in-order responses, then the 4th is accepted.
REQ-024 Streaming 8 Gets with d_ready=1 -> a_ready stays 1; 8 responses on consecutive cycles.
REQ-025 reset_n=0 pulse with 2 responses queued -> d_valid=0 immediately; no stale response after release.

Source files
------------

// File: rtl/tl_ul_sram_bridge.sv
// tl_ul_sram_bridge
// TileLink-UL (A/D channels) to single-port synchronous SRAM bridge.
//
// A legal request (PutFull/PutPartial/Get, size <= 4 bytes, naturally
// aligned) strobes the SRAM combinationally in the cycle it is accepted.
// The request metadata is held in stage s1 for one cycle, while the SRAM
// returns read data and error status. It is then pushed into a 3-entry
// response FIFO whose head drives the D channel. Illegal requests never
// touch the SRAM. They still produce exactly one (denied) response.
//
// Ports
//   clock, reset_n        : clock; asynchronous active-low reset
//   a_valid/a_ready       : A-channel handshake
//   a_opcode/a_param/a_size/a_source/a_address/a_mask/a_data : A payload
//                           (a_param is ignored)
//   d_valid/d_ready       : D-channel handshake
//   d_opcode/d_param/d_size/d_source/d_denied/d_data/d_corrupt : D payload
//   mem_req/mem_we/mem_addr/mem_wmask/mem_wdata : SRAM request (word address)
//   mem_rdata/mem_err     : SRAM read data / error, valid 1 cycle after mem_req
module tl_ul_sram_bridge #(
  parameter int ADDR_W    = 26,
  parameter int SRC_W     = 2,
  parameter int RSP_DEPTH = 3
) (
  input  logic              clock,
  input  logic              reset_n,

  input  logic              a_valid,
  output logic              a_ready,
  input  logic [2:0]        a_opcode,
  input  logic [2:0]        a_param,
  input  logic [2:0]        a_size,
  input  logic [SRC_W-1:0]  a_source,
  input  logic [ADDR_W-1:0] a_address,
  input  logic [3:0]        a_mask,
  input  logic [31:0]       a_data,

  output logic              d_valid,
  input  logic              d_ready,
  output logic [2:0]        d_opcode,
  output logic [1:0]        d_param,
  output logic [2:0]        d_size,
  output logic [SRC_W-1:0]  d_source,
  output logic              d_denied,
  output logic [31:0]       d_data,
  output logic              d_corrupt,

  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [3:0]        mem_wmask,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_err
);

  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int PW = $clog2(RSP_DEPTH);
  localparam logic [CW:0] DEPTH_L = (CW + 1)'(RSP_DEPTH);

  localparam logic [2:0] OP_ACK      = 3'd0;
  localparam logic [2:0] OP_ACK_DATA = 3'd1;
  localparam logic [2:0] OP_HINT_ACK = 3'd2;

  typedef struct packed {
    logic [2:0]       opcode;
    logic [2:0]       size;
    logic [SRC_W-1:0] source;
    logic             denied;
    logic             is_mem;
    logic             is_read;
  } s1_t;

  typedef struct packed {
    logic [2:0]       opcode;
    logic [2:0]       size;
    logic [SRC_W-1:0] source;
    logic             denied;
    logic [31:0]      data;
  } rsp_t;

  logic unused_param;
  assign unused_param = ^a_param;

  // ---------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------
  logic fire;
  logic op_put, op_get, op_hint;
  logic aligned, legal;
  logic [2:0] rsp_opcode;
  logic rsp_denied;

  assign op_put  = (a_opcode == 3'd0) || (a_opcode == 3'd1);
  assign op_get  = (a_opcode == 3'd4);
  assign op_hint = (a_opcode == 3'd5);

  always_comb begin
    aligned = 1'b0;
    case (a_size)
      3'd0:    aligned = 1'b1;
      3'd1:    aligned = ~a_address[0];
      3'd2:    aligned = (a_address[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  assign legal = (op_put || op_get) && aligned;

  // Intent always gets a clean HintAck; Put-class gets AccessAck; every
  // other opcode (Get, atomics, 6/7) answers with AccessAckData.
  always_comb begin
    rsp_opcode = OP_ACK_DATA;
    rsp_denied = ~legal;
    if (op_hint) begin
      rsp_opcode = OP_HINT_ACK;
      rsp_denied = 1'b0;
    end else if (op_put) begin
      rsp_opcode = OP_ACK;
    end
  end

  assign fire      = a_valid && a_ready;
  assign mem_req   = fire && legal;
  assign mem_we    = op_put;
  assign mem_addr  = a_address[ADDR_W-1:2];
  assign mem_wmask = a_mask;
  assign mem_wdata = a_data;

  // ---------------------------------------------------------------------
  // Stage s1 and response FIFO
  // ---------------------------------------------------------------------
  logic          s1_valid;
  s1_t           s1;
  logic [CW-1:0] count;
  logic [PW-1:0] wr_ptr, rd_ptr;
  rsp_t          rsp_store [RSP_DEPTH];
  rsp_t          push_entry, head;
  logic          push, pop;

  // Counting s1 as occupied reserves a FIFO slot for the response still in
  // flight, so the unconditional push from s1 can never overflow.
  assign a_ready = ({1'b0, count} + {{CW{1'b0}}, s1_valid}) < DEPTH_L;

  assign push = s1_valid;
  assign pop  = d_valid && d_ready;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    push_entry.opcode = s1.opcode;
    push_entry.size   = s1.size;
    push_entry.source = s1.source;
    push_entry.denied = s1.denied || (s1.is_mem && mem_err);
    push_entry.data   = (s1.is_mem && s1.is_read) ? mem_rdata : '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      s1_valid <= fire;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload registers carry no reset; they are only observed when valid.
  always_ff @(posedge clock) begin
    if (fire) begin
      s1.opcode  <= rsp_opcode;
      s1.size    <= a_size;
      s1.source  <= a_source;
      s1.denied  <= rsp_denied;
      s1.is_mem  <= legal;
      s1.is_read <= op_get;
    end
    if (push) rsp_store[wr_ptr] <= push_entry;
  end

  assign head      = rsp_store[rd_ptr];
  assign d_valid   = (count != '0);
  assign d_opcode  = head.opcode;
  assign d_param   = '0;
  assign d_size    = head.size;
  assign d_source  = head.source;
  assign d_denied  = head.denied;
  assign d_data    = head.data;
  assign d_corrupt = head.denied && (head.opcode == OP_ACK_DATA);

  no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
    !(push && !pop && (count == CW'(RSP_DEPTH))));

endmodule
